// File: rtl/fetch_sequencer.sv
`timescale 1ns/1ps
// Fetch controller: per line one REQ cycle, then up to two slots go out to decode over valid/ready.
// Latency: the first instruction is valid 2 cycles after start/redirect is sampled; each line takes 3 cycles at full rate.
// Backpressure: a presented slot holds until instr_ready; a redirect drops it. FETCH_PERF_EN adds perf_issued/perf_stall counters.
module fetch_sequencer #(
  parameter int LINE_AW  = 5,
  parameter int END_LINE = 31
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic [LINE_AW-1:0] im_sel,
  input  logic [63:0]        im_line,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [31:0]        instr,
  output logic               instr_compressed,
  output logic [LINE_AW:0]   instr_pc,
  input  logic               redirect_valid,
  input  logic [LINE_AW:0]   redirect_pc,
  output logic               busy,
`ifdef FETCH_PERF_EN
  output logic [15:0]        perf_issued,
  output logic [15:0]        perf_stall,
`endif
  output logic               done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ    = 3'd1,
    S_ISSUE0 = 3'd2,
    S_ISSUE1 = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [LINE_AW-1:0] sel_d;
  logic [63:0]        line_buf, line_buf_d;
  logic               start_slot, start_slot_d;

  logic [31:0]        slot;
  logic               issuing;
  logic               slot_nz;
  logic               advance;
  logic               is_rvc;
  logic               last_line;

  always_comb begin
    slot      = (state_q == S_ISSUE1) ? line_buf[31:0] : line_buf[63:32];
    issuing   = (state_q == S_ISSUE0) || (state_q == S_ISSUE1);
    slot_nz   = (slot != 32'h0);
    is_rvc    = (slot[1:0] != 2'b11);
    // Padding slots are skipped without ever being presented.
    advance   = issuing && (!slot_nz || instr_ready);
    last_line = (im_sel >= LINE_AW'(END_LINE));
  end

  always_comb begin
    instr_valid      = issuing && slot_nz;
    instr            = 32'h0;
    instr_compressed = 1'b0;
    instr_pc         = '0;
    if (instr_valid) begin
      instr            = is_rvc ? {16'h0, slot[15:0]} : slot;
      instr_compressed = is_rvc;
      instr_pc         = {im_sel, (state_q == S_ISSUE1)};
    end
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = im_sel;
    line_buf_d   = line_buf;
    start_slot_d = start_slot;
    if (redirect_valid) begin
      state_d      = S_REQ;
      sel_d        = redirect_pc[LINE_AW:1];
      start_slot_d = redirect_pc[0];
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_d      = S_REQ;
            sel_d        = '0;
            start_slot_d = 1'b0;
          end
        end
        S_REQ: begin
          line_buf_d = im_line;
          state_d    = start_slot ? S_ISSUE1 : S_ISSUE0;
        end
        S_ISSUE0: begin
          if (advance) state_d = S_ISSUE1;
        end
        S_ISSUE1: begin
          if (advance) begin
            // Lines past END_LINE (reachable only by redirect) also terminate.
            if (last_line) begin
              state_d = S_DONE;
            end else begin
              state_d      = S_REQ;
              sel_d        = im_sel + LINE_AW'(1);
              start_slot_d = 1'b0;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      im_sel     <= '0;
      line_buf   <= 64'h0;
      start_slot <= 1'b0;
    end else begin
      state_q    <= state_d;
      im_sel     <= sel_d;
      line_buf   <= line_buf_d;
      start_slot <= start_slot_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic perf_clear;
  assign perf_clear = start && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clk) begin
    if (reset || perf_clear) begin
      perf_issued <= 16'h0;
      perf_stall  <= 16'h0;
    end else begin
      if (instr_valid && instr_ready && (perf_issued != 16'hFFFF))
        perf_issued <= perf_issued + 16'h1;
      if (instr_valid && !instr_ready && (perf_stall != 16'hFFFF))
        perf_stall <= perf_stall + 16'h1;
    end
  end
`endif

endmodule
